pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//   Next-generation fetch PC generator for the RV32 core. Holds the fetch PC and selects the next
//   PC from sequential, branch/JAL target, JALR (ALU) target, trap vector and saved EPC.
//   Supports fetch stall, trap entry/return with an EPC register, and misaligned-target flagging.
//   Sits between the fetch stage and instruction memory; it replaces the basic PC register.
// PARAMETERS
//   XLEN          32            address width in bits
//   RESET_VECTOR  32'h0000_0000 PC value loaded on Reset
//   TRAP_VECTOR   32'h0000_0100 PC value loaded on trap entry
//   RAS_DEPTH     4             return-address-stack entries (power of 2, >=2; used only with RAS_EN)
// PORTS
//   CLK        in   1     clock, rising edge
//   Reset      in   1     synchronous, active-high reset
//   Stall      in   1     hold PC (fetch stall)
//   PCSrc      in   2     00 PC+4, 01 PCTarget, 10 ALUResult (JALR), 11 reserved (treated as 00)
//   PCTarget   in   XLEN  branch/JAL target
//   ALUResult  in   XLEN  JALR target (bit 0 cleared internally)
//   Trap       in   1     trap request; saves PC into EPC, jumps to TRAP_VECTOR
//   MRet       in   1     trap return; jumps to EPC
//   Call       in   1     push PC+4 onto RAS (RAS_EN only; ignored otherwise)
//   Ret        in   1     pop RAS (RAS_EN only; ignored otherwise)
//   PC         out  XLEN  current fetch PC (registered)
//   PCPlus4    out  XLEN  PC + 4, combinational, modulo 2^XLEN
//   EPC        out  XLEN  saved exception PC (registered)
//   Misaligned out  1     selected next PC has bits[1:0] != 0 (combinational)
//   RASTop     out  XLEN  predicted return address (top of stack); 0 when empty or RAS_EN absent
//   RASValid   out  1     RAS non-empty; constant 0 when RAS_EN absent
// BEHAVIOUR
//   - Reset (synchronous): PC<=RESET_VECTOR, EPC<=0, RAS count<=0; all other outputs follow.
//   - Next-PC priority per cycle: Reset > Trap > MRet > Stall > PCSrc mux.
//   - Trap: EPC<=PC, PC<=TRAP_VECTOR; overrides Stall. Trap and MRet together: Trap wins, EPC<=PC.
//   - MRet: PC<=EPC; EPC unchanged; overrides Stall.
//   - Stall (no Trap/MRet): PC holds; RAS not updated; Call/Ret ignored that cycle.
//   - JALR path: next PC = {ALUResult[XLEN-1:1],1'b0}.
//   - Latency: new PC visible one cycle after the selecting inputs are sampled.
//   - PCPlus4 wraps: PC=32'hFFFF_FFFC gives PCPlus4=0.
//   - Misaligned reflects the mux output even when the PC update is suppressed; it does not block
//     the update (trap decision belongs to the control unit).
// CONFIGURATION
//   RAS_EN defined: circular return-address stack, RAS_DEPTH entries, pointer + count registers.
//     Call only: push PCPlus4. Ret only: pop; RASTop shows the new top next cycle.
//     Call+Ret in the same cycle: replace the top entry with PCPlus4 (count unchanged; push if empty).
//     Push when full: overwrite the oldest entry; count saturates at RAS_DEPTH.
//     Pop when empty: no-op, RASValid stays 0. Trap/MRet do not modify the RAS. Reset empties it.
//   RAS_EN undefined: no RAS storage; Call/Ret ignored; RASTop=0, RASValid=0.
// TESTING
//   1 Reset held 2 cycles then released, PCSrc=00 -> PC 0,0,0,4,8; EPC=0.
//   2 PC=0x10, PCSrc=01 PCTarget=0x40 -> PC=0x40; PCSrc=10 ALUResult=0x87 -> PC=0x86, Misaligned=1.
//   3 PC=0x20, Stall=1 for 3 cycles -> PC stays 0x20; then Stall=1 with Trap=1 -> PC=0x100, EPC=0x20.
//   4 Trap at PC=0x30, then MRet=1 -> PC=0x30; Trap+MRet same cycle at PC=0x44 -> PC=0x100, EPC=0x44.
//   5 PC=0xFFFF_FFFC, PCSrc=00 -> PCPlus4=0, next PC=0.
//   6 RAS_EN, depth 4: 5 Calls at PC 0x0,0x4,0x8,0xC,0x10 -> RASTop=0x14; 4 Rets -> top 0x10,0xC,0x8
//     then RASValid=0; a further Ret is a no-op.

Source files
------------

// File: rtl/pc_gen_unit_if.sv
// Fetch PC generator control/status bundle.
// master = control/fetch side, slave = the PC generator.
interface pc_gen_unit_if #(
    parameter int XLEN = 32
);
    logic            Stall;
    logic [1:0]      PCSrc;
    logic [XLEN-1:0] PCTarget;
    logic [XLEN-1:0] ALUResult;
    logic            Trap;
    logic            MRet;
    logic            Call;
    logic            Ret;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] EPC;
    logic            Misaligned;
    logic [XLEN-1:0] RASTop;
    logic            RASValid;

    modport master (
        output Stall, PCSrc, PCTarget, ALUResult,
        output Trap, MRet, Call, Ret,
        input  PC, PCPlus4, EPC, Misaligned,
        input  RASTop, RASValid
    );

    modport slave (
        input  Stall, PCSrc, PCTarget, ALUResult,
        input  Trap, MRet, Call, Ret,
        output PC, PCPlus4, EPC, Misaligned,
        output RASTop, RASValid
    );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: next-PC mux, trap entry/return with EPC.
// Optional return-address stack enabled by defining RAS_EN.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    pc_gen_unit_if.slave  bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] mux_pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] epc_nxt;
    logic            seq_adv;

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        mux_pc = pc_plus4;
        unique case (bus.PCSrc)
            2'b01:   mux_pc = bus.PCTarget;
            2'b10:   mux_pc = {bus.ALUResult[XLEN-1:1], 1'b0};
            default: mux_pc = pc_plus4;
        endcase
    end

    // Trap beats MRet beats Stall; only a plain advance touches the RAS.
    always_comb begin
        pc_nxt  = pc_q;
        epc_nxt = epc_q;
        seq_adv = 1'b0;
        if (bus.Trap) begin
            epc_nxt = pc_q;
            pc_nxt  = TRAP_VECTOR;
        end else if (bus.MRet) begin
            pc_nxt = epc_q;
        end else if (!bus.Stall) begin
            pc_nxt  = mux_pc;
            seq_adv = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_nxt;
            epc_q <= epc_nxt;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_plus4;
    assign bus.EPC        = epc_q;
    assign bus.Misaligned = |mux_pc[1:0];

`ifdef RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   ptr_inc;
    logic            empty;
    logic            full;
    logic            do_push;
    logic            do_pop;
    logic            do_repl;

    assign ptr_inc = ptr_q + PW'(1);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(RAS_DEPTH));

    // Call+Ret swaps the top entry, degenerating to a push when empty.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_repl = 1'b0;
        if (seq_adv && !Reset) begin
            unique case ({bus.Call, bus.Ret})
                2'b10:   do_push = 1'b1;
                2'b01:   do_pop  = !empty;
                2'b11: begin
                    do_push = empty;
                    do_repl = !empty;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (do_push) begin
            ptr_q <= ptr_inc;
            if (!full) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (do_pop) begin
            ptr_q <= ptr_q - PW'(1);
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // A full stack wraps onto the oldest slot, overwriting it.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            ras_q[ptr_inc] <= pc_plus4;
        end else if (do_repl) begin
            ras_q[ptr_q] <= pc_plus4;
        end
    end

    assign bus.RASTop   = empty ? '0 : ras_q[ptr_q];
    assign bus.RASValid = !empty;
`else
    logic unused_ras;

    assign unused_ras   = ^{bus.Call, bus.Ret, seq_adv};
    assign bus.RASTop   = '0;
    assign bus.RASValid = 1'b0;
`endif

    logic unused_alu;

    assign unused_alu = bus.ALUResult[0];

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios then random traffic
// against a queue-based reference model.
module tb_pc_gen_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          RD = 4;

    logic CLK = 1'b0;
    logic Reset;

    pc_gen_unit_if #(.XLEN(32)) bus ();

    pc_gen_unit #(
        .XLEN(32),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR(TV),
        .RAS_DEPTH(RD)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_ras[$];
    bit          m_valid = 1'b0;
    logic [31:0] last_p4;
    logic        last_mis;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit st, input logic [1:0] src,
                        input logic [31:0] tgt, input logic [31:0] alu,
                        input bit tr, input bit mr,
                        input bit ca, input bit re);
        logic [31:0] sel;
        Reset         = r;
        bus.Stall     = st;
        bus.PCSrc     = src;
        bus.PCTarget  = tgt;
        bus.ALUResult = alu;
        bus.Trap      = tr;
        bus.MRet      = mr;
        bus.Call      = ca;
        bus.Ret       = re;
        #1;
        last_p4  = bus.PCPlus4;
        last_mis = bus.Misaligned;
        sel = (src == 2'b01) ? tgt :
              (src == 2'b10) ? (alu & ~32'd1) : m_pc + 32'd4;
        if (m_valid) begin
            chk("pcplus4", {31'd0, 1'b0} | bus.PCPlus4, m_pc + 32'd4);
            chk("misaligned", {31'd0, bus.Misaligned},
                {31'd0, (sel % 4) != 0});
        end
        @(posedge CLK);
        if (r) begin
            m_pc    = RV;
            m_epc   = 32'd0;
            m_ras   = {};
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (tr) begin
                m_epc = m_pc;
                m_pc  = TV;
            end else if (mr) begin
                m_pc = m_epc;
            end else if (!st) begin
`ifdef RAS_EN
                if (ca && !re) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > RD) void'(m_ras.pop_front());
                end else if (re && !ca) begin
                    if (m_ras.size() > 0) void'(m_ras.pop_back());
                end else if (ca && re) begin
                    if (m_ras.size() == 0) m_ras.push_back(m_pc + 32'd4);
                    else m_ras[m_ras.size()-1] = m_pc + 32'd4;
                end
`endif
                m_pc = sel;
            end
        end
        #1;
        if (m_valid) begin
            chk("pc", bus.PC, m_pc);
            chk("epc", bus.EPC, m_epc);
            chk("rastop", bus.RASTop,
                (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0);
            chk("rasvalid", {31'd0, bus.RASValid},
                {31'd0, m_ras.size() > 0});
        end
    endtask

    task automatic go(input logic [31:0] a);
        step(0, 0, 2'b01, a, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held two cycles, then sequential fetch
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("t1_pc0", bus.PC, 32'h0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("t1_epc", bus.EPC, 32'h0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("t1_pc4", bus.PC, 32'h4);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("t1_pc8", bus.PC, 32'h8);

        // Branch and JALR targets
        go(32'h10);
        go(32'h40);
        chk("t2_br", bus.PC, 32'h40);
        step(0, 0, 2'b10, 0, 32'h87, 0, 0, 0, 0);
        chk("t2_jalr", bus.PC, 32'h86);
        chk("t2_mis", {31'd0, last_mis}, 32'd1);
        step(0, 0, 2'b11, 32'h13, 0, 0, 0, 0, 0);
        chk("t2_rsv", bus.PC, 32'h8A);

        // Stall, then trap overriding stall
        go(32'h20);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'b01, 32'h99, 0, 0, 0, 0, 0);
            chk("t3_stall", bus.PC, 32'h20);
        end
        step(0, 1, 2'b00, 0, 0, 1, 0, 0, 0);
        chk("t3_trap_pc", bus.PC, 32'h100);
        chk("t3_trap_epc", bus.EPC, 32'h20);

        // Trap/MRet round trip, then both together
        go(32'h30);
        step(0, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        step(0, 1, 2'b00, 0, 0, 0, 1, 0, 0);
        chk("t4_mret", bus.PC, 32'h30);
        go(32'h44);
        step(0, 0, 2'b00, 0, 0, 1, 1, 0, 0);
        chk("t4_both_pc", bus.PC, 32'h100);
        chk("t4_both_epc", bus.EPC, 32'h44);

        // PC+4 wraparound
        go(32'hFFFF_FFFC);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("t5_p4", last_p4, 32'h0);
        chk("t5_wrap", bus.PC, 32'h0);

        // Return-address stack overflow and drain
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
`ifdef RAS_EN
        chk("t6_top", bus.RASTop, 32'h14);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        chk("t6_pop1", bus.RASTop, 32'h10);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        chk("t6_pop2", bus.RASTop, 32'hC);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        chk("t6_pop3", bus.RASTop, 32'h8);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        chk("t6_empty", {31'd0, bus.RASValid}, 32'd0);
`else
        chk("t6_off_top", bus.RASTop, 32'h0);
        chk("t6_off_vld", {31'd0, bus.RASValid}, 32'd0);
`endif
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            logic [31:0] a;
            t = $urandom;
            a = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            step($urandom_range(39) == 0,
                 $urandom_range(4) == 0,
                 2'($urandom_range(3)),
                 t, a,
                 $urandom_range(11) == 0,
                 $urandom_range(11) == 0,
                 $urandom_range(3) == 0,
                 $urandom_range(3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
